cmp4_minmax_tracker: RTL and testbench
======================================

Name: cmp4_minmax_tracker

Overview:
- Sequential controller that sits directly upstream and downstream of the team's 4-bit combinational magnitude comparator.
- Accepts a frame of 4-bit samples over a valid/ready handshake and drives the comparator's A/B operands. It consumes the equal/greater/less flags to track the frame's running maximum, minimum and maximum-occurrence count.
- One shared comparator is time-multiplexed between the max check and the min check.

Parameters:
- LEN_W, 4, width of frame_len and max_cnt; frames of 0..2^LEN_W-1 samples.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  begin a new frame; sampled only in IDLE.
- frame_len  in  LEN_W  number of samples in the frame; latched on accepted start.
- in_valid  in  1  sample valid.
- in_data  in  4  sample value, unsigned.
- in_ready  out  1  high only in WAIT.
- cmp_a  out  4  comparator operand A.
- cmp_b  out  4  comparator operand B.
- cmp_eq  in  1  comparator A==B, combinational from cmp_a/cmp_b, same cycle.
- cmp_gt  in  1  comparator A>B.
- cmp_lt  in  1  comparator A<B.
- max_out  out  4  frame maximum.
- min_out  out  4  frame minimum.
- max_cnt  out  LEN_W  number of samples equal to the final maximum.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when results are final.
- cmp_err  out  1  sticky: comparator flags were not one-hot during a compare.

Behaviour:
- Reset (async, rst_n=0): state IDLE.
  - All outputs 0, including max_out, min_out, max_cnt, cmp_err, done, busy and in_ready.
  - Internal sample register, remaining counter and first flag are cleared.
  - Reset mid-frame abandons the frame with no done pulse.
- States: IDLE, WAIT, CMP_MAX, CMP_MIN, DONE.
- IDLE:
  - On start=1: latch frame_len into remaining; clear max_cnt and cmp_err; set first=1.
  - If frame_len==0: go to DONE; max_out, min_out and max_cnt are forced to 0.
  - Otherwise go to WAIT.
  - Results from the previous frame hold until this start is accepted.
- WAIT: in_ready=1. On in_valid & in_ready, latch in_data into s_reg and decrement remaining.
  - If first=1: max_out=min_out=in_data, max_cnt=1, first=0. Go to DONE if the new remaining==0, else stay in WAIT. Takes 1 cycle.
  - If first=0: go to CMP_MAX.
- CMP_MAX: cmp_a=s_reg, cmp_b=max_out.
  - gt: max_out<=s_reg, max_cnt<=1.
  - eq: max_cnt<=max_cnt+1. Cannot overflow because max_cnt<=frame_len.
  - lt: no change.
  - Go to CMP_MIN.
- CMP_MIN: cmp_a=s_reg, cmp_b=min_out.
  - lt: min_out<=s_reg.
  - eq/gt: no change.
  - Go to DONE if remaining==0, else WAIT.
- DONE: done=1 for exactly one cycle, busy=1; go to IDLE.
- cmp_a and cmp_b are 0 in IDLE, WAIT and DONE.
- Throughput: 1 cycle for the first sample; 3 cycles per later sample (WAIT accept, CMP_MAX, CMP_MIN) when in_valid is held high.
- Flag fault:
  - In CMP_MAX or CMP_MIN, if {cmp_eq,cmp_gt,cmp_lt} is not exactly one-hot, set cmp_err=1.
  - The registers are not updated (treated as no-change).
  - Sequencing continues normally.
  - cmp_err clears only on reset or on an accepted start.
- Ignored inputs:
  - start is ignored when busy=1.
  - in_valid and in_data are ignored outside WAIT.
  - frame_len is read only on an accepted start.

Test Plan:
- rst_n=0 asynchronously in CMP_MAX mid-frame -> all outputs 0 immediately, state IDLE, no done pulse. After release, start with frame_len=1 and sample 3 -> max_out=3, min_out=3, max_cnt=1, done pulses.
- frame_len=4, samples 5,9,2,9 with in_valid always high (bench models the comparator) -> max_out=9, min_out=2, max_cnt=2. done pulses exactly once, 1+3+3+3 cycles after the first accept, plus the DONE cycle.
- frame_len=1, sample 7 -> max_out=7, min_out=7, max_cnt=1; no CMP states are entered; cmp_a/cmp_b stay 0.
- frame_len=0 -> DONE on the cycle after start, done=1 with max_out=0, min_out=0, max_cnt=0; in_ready never asserts.
- Bench forces cmp_eq=1 and cmp_gt=1 during CMP_MAX of sample 2 (frame 4,12) -> cmp_err=1, max_out stays 4, min_out=4, frame completes. The next accepted start clears cmp_err.
- Stall and ignored inputs: frame_len=3 with samples 0xF,0xF,0xF and 5-cycle in_valid gaps -> max_out=0xF, min_out=0xF, max_cnt=3. A start pulse while busy is ignored, and in_valid asserted during CMP states is not consumed.

Source files
------------

// File: rtl/cmp4_minmax_tracker.sv
// Frame min/max tracker that time-shares one external 4-bit magnitude comparator
// between the running-maximum check and the running-minimum check.
module cmp4_minmax_tracker #(
  parameter int unsigned LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             in_valid,
  input  logic [3:0]       in_data,
  output logic             in_ready,
  output logic [3:0]       cmp_a,
  output logic [3:0]       cmp_b,
  input  logic             cmp_eq,
  input  logic             cmp_gt,
  input  logic             cmp_lt,
  output logic [3:0]       max_out,
  output logic [3:0]       min_out,
  output logic [LEN_W-1:0] max_cnt,
  output logic             busy,
  output logic             done,
  output logic             cmp_err
);

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StCmpMax,
    StCmpMin,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic             first_q, first_d;
  logic [3:0]       s_reg_q, s_reg_d;
  logic [3:0]       max_q, max_d;
  logic [3:0]       min_q, min_d;
  logic [LEN_W-1:0] max_cnt_q, max_cnt_d;
  logic             cmp_err_q, cmp_err_d;
  logic [2:0]       flags;

  assign flags = {cmp_eq, cmp_gt, cmp_lt};

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    first_d     = first_q;
    s_reg_d     = s_reg_q;
    max_d       = max_q;
    min_d       = min_q;
    max_cnt_d   = max_cnt_q;
    cmp_err_d   = cmp_err_q;
    in_ready    = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    cmp_a       = 4'd0;
    cmp_b       = 4'd0;

    case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (start) begin
          remaining_d = frame_len;
          max_cnt_d   = '0;
          cmp_err_d   = 1'b0;
          first_d     = 1'b1;
          if (frame_len == '0) begin
            max_d   = 4'd0;
            min_d   = 4'd0;
            state_d = StDone;
          end else begin
            state_d = StWait;
          end
        end
      end

      StWait: begin
        in_ready = 1'b1;
        if (in_valid) begin
          s_reg_d     = in_data;
          remaining_d = remaining_q - 1'b1;
          if (first_q) begin
            // First sample seeds both extremes directly; no compare needed.
            max_d     = in_data;
            min_d     = in_data;
            max_cnt_d = LEN_W'(1);
            first_d   = 1'b0;
            state_d   = (remaining_q == LEN_W'(1)) ? StDone : StWait;
          end else begin
            state_d = StCmpMax;
          end
        end
      end

      StCmpMax: begin
        cmp_a = s_reg_q;
        cmp_b = max_q;
        unique case (flags)
          3'b100:  max_cnt_d = max_cnt_q + 1'b1;
          3'b010: begin
            max_d     = s_reg_q;
            max_cnt_d = LEN_W'(1);
          end
          3'b001:  ;
          default: cmp_err_d = 1'b1;
        endcase
        state_d = StCmpMin;
      end

      StCmpMin: begin
        cmp_a = s_reg_q;
        cmp_b = min_q;
        unique case (flags)
          3'b001:          min_d = s_reg_q;
          3'b100, 3'b010:  ;
          default:         cmp_err_d = 1'b1;
        endcase
        state_d = (remaining_q == '0) ? StDone : StWait;
      end

      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      first_q     <= 1'b0;
      s_reg_q     <= 4'd0;
      max_q       <= 4'd0;
      min_q       <= 4'd0;
      max_cnt_q   <= '0;
      cmp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      first_q     <= first_d;
      s_reg_q     <= s_reg_d;
      max_q       <= max_d;
      min_q       <= min_d;
      max_cnt_q   <= max_cnt_d;
      cmp_err_q   <= cmp_err_d;
    end
  end

  assign max_out = max_q;
  assign min_out = min_q;
  assign max_cnt = max_cnt_q;
  assign cmp_err = cmp_err_q;

endmodule

// File: tb/tb_cmp4_minmax_tracker.sv
// Bench for cmp4_minmax_tracker: models the external comparator, drives frames from a
// vector table, hand-written corner sequences and random frames against a min/max model.
module tb_cmp4_minmax_tracker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] frame_len = 4'd0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = 4'd0;
  logic       in_ready;
  logic [3:0] cmp_a, cmp_b;
  logic       cmp_eq, cmp_gt, cmp_lt;
  logic [3:0] max_out, min_out, max_cnt;
  logic       busy, done, cmp_err;
  logic       fault = 1'b0;

  int tests = 0;
  int fails = 0;

  cmp4_minmax_tracker #(.LEN_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .frame_len (frame_len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .cmp_a     (cmp_a),
    .cmp_b     (cmp_b),
    .cmp_eq    (cmp_eq),
    .cmp_gt    (cmp_gt),
    .cmp_lt    (cmp_lt),
    .max_out   (max_out),
    .min_out   (min_out),
    .max_cnt   (max_cnt),
    .busy      (busy),
    .done      (done),
    .cmp_err   (cmp_err)
  );

  always #5 clk = ~clk;

  // Comparator model; fault forces an illegal eq+gt pattern.
  always_comb begin
    cmp_eq = (cmp_a == cmp_b);
    cmp_gt = (cmp_a > cmp_b);
    cmp_lt = (cmp_a < cmp_b);
    if (fault) begin
      cmp_eq = 1'b1;
      cmp_gt = 1'b1;
      cmp_lt = 1'b0;
    end
  end

  int         cyc = 0;
  int         acc_cnt, done_cnt, done_cyc, first_acc, start_cyc;
  bit         rdy_seen, cmp_nz, cap_err;
  logic [3:0] cap_max, cap_min;
  int         cap_cnt;

  always @(negedge clk) begin
    cyc++;
    if (start && !busy) start_cyc = cyc;
    if (in_valid && in_ready) begin
      acc_cnt++;
      if (first_acc < 0) first_acc = cyc;
    end
    if (in_ready) rdy_seen = 1'b1;
    if (cmp_a != 4'd0 || cmp_b != 4'd0) cmp_nz = 1'b1;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      cap_max  = max_out;
      cap_min  = min_out;
      cap_cnt  = int'(max_cnt);
      cap_err  = cmp_err;
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " max_out"}, int'(max_out), 0);
    chk({tag, " min_out"}, int'(min_out), 0);
    chk({tag, " max_cnt"}, int'(max_cnt), 0);
    chk({tag, " cmp_err"}, int'(cmp_err), 0);
    chk({tag, " done"}, int'(done), 0);
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " in_ready"}, int'(in_ready), 0);
    chk({tag, " cmp_a"}, int'(cmp_a), 0);
    chk({tag, " cmp_b"}, int'(cmp_b), 0);
  endtask

  task automatic clear_mon();
    acc_cnt   = 0;
    done_cnt  = 0;
    done_cyc  = -1;
    first_acc = -1;
    start_cyc = -1;
    rdy_seen  = 1'b0;
    cmp_nz    = 1'b0;
  endtask

  // Runs one frame. gap: idle cycles before each sample. noise: pulse start while busy
  // during gaps and hold junk in_valid through the compare cycles. fault_idx: sample whose
  // CMP_MAX cycle gets illegal flags (-1 for none).
  task automatic run_frame(input int len, input logic [3:0] smp[16], input int gap,
                           input bit noise, input int fault_idx);
    int t;
    clear_mon();
    @(posedge clk); #1;
    start     = 1'b1;
    frame_len = 4'(len);
    @(posedge clk); #1;
    start     = 1'b0;
    frame_len = 4'($urandom_range(0, 15));
    for (int i = 0; i < len; i++) begin
      for (int g = 0; g < gap; g++) begin
        start = noise;
        @(posedge clk); #1;
      end
      start    = 1'b0;
      in_valid = 1'b1;
      in_data  = smp[i];
      t = 0;
      while (!in_ready && t < 100) begin
        @(posedge clk); #1;
        t++;
      end
      if (t == 100) chk("ready timeout", 0, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (fault_idx == i) begin
        fault = 1'b1;
        @(posedge clk); #1;
        fault = 1'b0;
      end else if (noise && i > 0) begin
        in_valid = 1'b1;
        in_data  = 4'd0;
        repeat (2) begin
          @(posedge clk); #1;
        end
        in_valid = 1'b0;
      end
    end
    t = 0;
    while (done_cnt == 0 && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    if (t == 300) chk("done timeout", 0, 1);
    repeat (3) begin
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    int              len;
    logic [3:0][3:0] s;
    logic [3:0]      emax;
    logic [3:0]      emin;
    int              ecnt;
  } vec_t;

  vec_t       tbl[5];
  logic [3:0] smp[16];

  initial begin
    tbl[0] = '{4, {4'd9, 4'd2, 4'd9, 4'd5}, 4'd9, 4'd2, 2};
    tbl[1] = '{1, {4'd0, 4'd0, 4'd0, 4'd7}, 4'd7, 4'd7, 1};
    tbl[2] = '{0, {4'd5, 4'd5, 4'd5, 4'd5}, 4'd0, 4'd0, 0};
    tbl[3] = '{3, {4'd0, 4'd1, 4'd3, 4'd3}, 4'd3, 4'd1, 2};
    tbl[4] = '{2, {4'd0, 4'd0, 4'd15, 4'd0}, 4'd15, 4'd0, 1};

    #3;
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Vector table, in_valid held high (gap 0).
    foreach (tbl[k]) begin
      for (int i = 0; i < 16; i++) smp[i] = (i < 4) ? tbl[k].s[i] : 4'd0;
      run_frame(tbl[k].len, smp, 0, 1'b0, -1);
      chk($sformatf("tbl%0d max", k), int'(cap_max), int'(tbl[k].emax));
      chk($sformatf("tbl%0d min", k), int'(cap_min), int'(tbl[k].emin));
      chk($sformatf("tbl%0d cnt", k), cap_cnt, tbl[k].ecnt);
      chk($sformatf("tbl%0d done pulses", k), done_cnt, 1);
      chk($sformatf("tbl%0d err", k), int'(cap_err), 0);
      if (tbl[k].len == 0) begin
        chk("len0 in_ready seen", int'(rdy_seen), 0);
        chk("len0 done latency", done_cyc - start_cyc, 1);
      end else begin
        chk($sformatf("tbl%0d done latency", k), done_cyc - first_acc, 1 + 3 * (tbl[k].len - 1));
      end
      if (tbl[k].len == 1) chk("len1 cmp operands nonzero", int'(cmp_nz), 0);
    end

    // Illegal comparator flags on sample 2's max check.
    smp[0] = 4'd4;
    smp[1] = 4'd12;
    run_frame(2, smp, 0, 1'b0, 1);
    chk("fault err", int'(cap_err), 1);
    chk("fault max", int'(cap_max), 4);
    chk("fault min", int'(cap_min), 4);
    chk("fault cnt", cap_cnt, 1);
    chk("fault done pulses", done_cnt, 1);
    chk("fault err sticky", int'(cmp_err), 1);
    @(posedge clk); #1;
    start     = 1'b1;
    frame_len = 4'd1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("err cleared by start", int'(cmp_err), 0);
    in_valid = 1'b1;
    in_data  = 4'd6;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end

    // Stalls, start while busy, in_valid during compare cycles.
    for (int i = 0; i < 3; i++) smp[i] = 4'hF;
    run_frame(3, smp, 5, 1'b1, -1);
    chk("stall max", int'(cap_max), 15);
    chk("stall min", int'(cap_min), 15);
    chk("stall cnt", cap_cnt, 3);
    chk("stall accepts", acc_cnt, 3);
    chk("stall done pulses", done_cnt, 1);

    // Asynchronous reset in CMP_MAX.
    clear_mon();
    @(posedge clk); #1;
    start     = 1'b1;
    frame_len = 4'd4;
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 4'd5;
    @(posedge clk); #1;
    in_data = 4'd9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre-reset cmp_a", int'(cmp_a), 9);
    chk("pre-reset cmp_b", int'(cmp_b), 5);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("mid-frame reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("reset no done", done_cnt, 0);
    smp[0] = 4'd3;
    run_frame(1, smp, 0, 1'b0, -1);
    chk("post-reset max", int'(cap_max), 3);
    chk("post-reset min", int'(cap_min), 3);
    chk("post-reset cnt", cap_cnt, 1);
    chk("post-reset done", done_cnt, 1);

    // Random frames against a plain min/max/count model.
    for (int r = 0; r < 40; r++) begin
      int len, gap, emax, emin, ecnt;
      len = $urandom_range(0, 15);
      gap = $urandom_range(0, 2);
      for (int i = 0; i < 16; i++)
        smp[i] = (r % 2 == 0) ? 4'($urandom_range(6, 9)) : 4'($urandom_range(0, 15));
      emax = 0;
      emin = 15;
      ecnt = 0;
      for (int i = 0; i < len; i++) begin
        if (int'(smp[i]) > emax) emax = int'(smp[i]);
        if (int'(smp[i]) < emin) emin = int'(smp[i]);
      end
      for (int i = 0; i < len; i++) if (int'(smp[i]) == emax) ecnt++;
      if (len == 0) emin = 0;
      run_frame(len, smp, gap, 1'b0, -1);
      chk($sformatf("rnd%0d max", r), int'(cap_max), emax);
      chk($sformatf("rnd%0d min", r), int'(cap_min), emin);
      chk($sformatf("rnd%0d cnt", r), cap_cnt, ecnt);
      chk($sformatf("rnd%0d done pulses", r), done_cnt, 1);
      chk($sformatf("rnd%0d accepts", r), acc_cnt, len);
      if (gap == 0 && len > 0)
        chk($sformatf("rnd%0d latency", r), done_cyc - first_acc, 1 + 3 * (len - 1));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
